// File: rtl/rr_arb_2_1.sv
// Two-input round-robin arbiter feeding a one-entry registered output slot.
// sel tracks the source of the held data so the downstream mux stays coherent.
module rr_arb_2_1 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sel
);

   logic accept;
   logic grant_a;
   logic grant_b;
   logic last_grant;

   assign accept = !out_valid || out_ready;

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (accept) begin
         unique case ({a_valid, b_valid})
            2'b10: grant_a = 1'b1;
            2'b01: grant_b = 1'b1;
            2'b11: begin
               // contention goes to whoever did not win last
               grant_a = last_grant;
               grant_b = !last_grant;
            end
            default: ;
         endcase
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         sel        <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         if (grant_a || grant_b) begin
            out_valid  <= 1'b1;
            out_data   <= grant_b ? b_data : a_data;
            sel        <= grant_b;
            last_grant <= grant_b;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_2_1.sv
// Directed bench for rr_arb_2_1: streaming, alternation, stall,
// lone-requester priority, idle drain and asynchronous reset.
module tb_rr_arb_2_1;

   logic       clk;
   logic       rst_n;
   logic       a_valid;
   logic [7:0] a_data;
   logic       a_ready;
   logic       b_valid;
   logic [7:0] b_data;
   logic       b_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       sel;

   int passed;
   int total;

   rr_arb_2_1 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one cycle of inputs, check readies before the edge and the
   // registered slot just after it.
   task automatic cyc(input string tag,
                      input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd,
                      input logic ordy,
                      input logic ear, input logic ebr,
                      input logic eov, input logic [7:0] eod,
                      input logic esel);
      a_valid   = av;
      a_data    = ad;
      b_valid   = bv;
      b_data    = bd;
      out_ready = ordy;
      #1;
      chk({tag, ".a_ready"}, a_ready, ear);
      chk({tag, ".b_ready"}, b_ready, ebr);
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, out_valid, eov);
      chk({tag, ".out_data"}, out_data, eod);
      chk({tag, ".sel"}, sel, esel);
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      rst_n     = 1'b0;
      a_valid   = 1'b0;
      a_data    = 8'h00;
      b_valid   = 1'b0;
      b_data    = 8'h00;
      out_ready = 1'b0;
      #12;
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.out_data", out_data, 8'h00);
      chk("rst.sel", sel, 1'b0);
      rst_n = 1'b1;

      // A streams alone
      cyc("a0", 1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0);
      cyc("a1", 1, 8'h22, 0, 8'h00, 1, 1, 0, 1, 8'h22, 0);
      cyc("a2", 1, 8'h33, 0, 8'h00, 1, 1, 0, 1, 8'h33, 0);
      // idle: slot drains, data retained
      cyc("idle", 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h33, 0);

      // B alone twice, then contention goes to A
      cyc("b0", 0, 8'h00, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1);
      cyc("b1", 0, 8'h00, 1, 8'hB2, 1, 0, 1, 1, 8'hB2, 1);
      cyc("ab0", 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 1, 8'hA0, 0);
      cyc("ab1", 1, 8'hA0, 1, 8'hB0, 1, 0, 1, 1, 8'hB0, 1);
      cyc("ab2", 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 1, 8'hA0, 0);
      cyc("ab3", 1, 8'hA0, 1, 8'hB0, 1, 0, 1, 1, 8'hB0, 1);

      // stall with both valid
      cyc("st0", 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 1, 8'hA0, 0);
      cyc("st1", 1, 8'hA0, 1, 8'hB0, 0, 0, 0, 1, 8'hA0, 0);
      cyc("st2", 1, 8'hA0, 1, 8'hB0, 0, 0, 0, 1, 8'hA0, 0);
      cyc("st3", 1, 8'hA0, 1, 8'hB0, 0, 0, 0, 1, 8'hA0, 0);
      cyc("st4", 1, 8'hA0, 1, 8'hB0, 1, 0, 1, 1, 8'hB0, 1);

      // asynchronous reset while the slot is full
      rst_n = 1'b0;
      #1;
      chk("arst.out_valid", out_valid, 1'b0);
      chk("arst.out_data", out_data, 8'h00);
      chk("arst.sel", sel, 1'b0);
      #1;
      rst_n = 1'b1;
      cyc("post", 1, 8'hA5, 1, 8'hB5, 1, 1, 0, 1, 8'hA5, 0);
      cyc("post1", 1, 8'hA6, 1, 8'hB6, 1, 0, 1, 1, 8'hB6, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
